reducer_input_arbiter: RTL

- Round-robin, packet-atomic arbiter that shares the wide write side of the bit-width reducer between NUM_CH producer channels.
- Sits directly upstream of the reducer and drives its DIN/DIN_VALID, throttled by the reducer's CONVERT_READY.
- Provides a stall watchdog so a producer that stalls mid-packet cannot lock out the other channels.

---
 rtl/reducer_input_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/reducer_input_arbiter.sv
// ----------------------------------------------------------------------------
// reducer_input_arbiter
//
// Round-robin, packet-atomic arbiter sharing the wide write side of the
// bit-width reducer between NUM_CH producer channels. Once a channel is
// granted, it owns the reducer until its LAST beat or until the stall
// watchdog aborts the packet.
//
// Ports:
//   CLK            single clock (reducer write-clock domain)
//   RESET          asynchronous, active-high reset
//   CH_VALID       per-channel word valid
//   CH_LAST        per-channel end-of-packet, qualified by CH_VALID
//   CH_DATA        flattened channel words, channel i at [DIN_WIDTH*i +: DIN_WIDTH]
//   CH_READY       per-channel accept (only the owner's bit can be high)
//   CH_ENABLE      channel mask, looked at only when arbitrating
//   CONVERT_READY  reducer ready (registered FIFO-not-full)
//   DIN            word to reducer
//   DIN_VALID      write strobe to reducer
//   GRANT          one-hot current owner, zero when idle
//   TIMEOUT_FLAG   sticky, set on any watchdog abort
// ----------------------------------------------------------------------------
module reducer_input_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int DIN_WIDTH      = 128,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [NUM_CH-1:0]             CH_VALID,
    input  logic [NUM_CH-1:0]             CH_LAST,
    input  logic [NUM_CH*DIN_WIDTH-1:0]   CH_DATA,
    output logic [NUM_CH-1:0]             CH_READY,
    input  logic [NUM_CH-1:0]             CH_ENABLE,
    input  logic                          CONVERT_READY,
    output logic [DIN_WIDTH-1:0]          DIN,
    output logic                          DIN_VALID,
    output logic [NUM_CH-1:0]             GRANT,
    output logic                          TIMEOUT_FLAG
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t               state_reg,        state_next;
    logic [NUM_CH-1:0]    grant_reg,        grant_next;
    logic [IDX_W-1:0]     owner_reg,        owner_next;
    logic [IDX_W-1:0]     last_grant_reg,   last_grant_next;
    logic [CNT_W-1:0]     wd_cnt_reg,       wd_cnt_next;
    logic [DIN_WIDTH-1:0] din_reg,          din_next;
    logic                 din_valid_reg,    din_valid_next;
    logic                 timeout_flag_reg, timeout_flag_next;

    // Unpacked view of the flattened channel words.
    logic [DIN_WIDTH-1:0] ch_word [NUM_CH];

    // cand_idx[k] is the channel at priority position k, i.e. the k-th
    // channel after last_grant going upward with wrap-around.
    logic [IDX_W-1:0] cand_idx [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign ch_word[gi]  = CH_DATA[gi*DIN_WIDTH +: DIN_WIDTH];
            assign cand_idx[gi] = IDX_W'((int'(last_grant_reg) + gi + 1) % NUM_CH);
        end
    endgenerate

    logic [NUM_CH-1:0] req;
    logic [IDX_W-1:0]  pick_idx;
    logic              owner_valid;
    logic              beat;
    logic              stall;

    assign req         = CH_VALID & CH_ENABLE;
    assign owner_valid = CH_VALID[owner_reg];
    assign beat        = (state_reg == ST_XFER) && CONVERT_READY && owner_valid;
    // Watchdog only counts when the reducer could accept but the owner has
    // nothing; reducer backpressure never ages the packet.
    assign stall       = (state_reg == ST_XFER) && CONVERT_READY && !owner_valid;

    // Priority pick: walk from lowest to highest priority so the closest
    // requester after last_grant is the one left standing.
    always_comb begin
        pick_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                pick_idx = cand_idx[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg        <= ST_IDLE;
            grant_reg        <= '0;
            owner_reg        <= '0;
            last_grant_reg   <= IDX_W'(NUM_CH - 1);
            wd_cnt_reg       <= '0;
            din_reg          <= '0;
            din_valid_reg    <= 1'b0;
            timeout_flag_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            grant_reg        <= grant_next;
            owner_reg        <= owner_next;
            last_grant_reg   <= last_grant_next;
            wd_cnt_reg       <= wd_cnt_next;
            din_reg          <= din_next;
            din_valid_reg    <= din_valid_next;
            timeout_flag_reg <= timeout_flag_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next        = state_reg;
        grant_next        = grant_reg;
        owner_next        = owner_reg;
        last_grant_next   = last_grant_reg;
        wd_cnt_next       = wd_cnt_reg;
        din_next          = din_reg;
        din_valid_next    = 1'b0;
        timeout_flag_next = timeout_flag_reg;

        case (state_reg)
            ST_IDLE: begin
                grant_next = '0;
                // Grant only; the first word is taken in the following cycle.
                if ((req != '0) && CONVERT_READY) begin
                    state_next           = ST_XFER;
                    grant_next[pick_idx] = 1'b1;
                    owner_next           = pick_idx;
                    wd_cnt_next          = '0;
                end
            end

            ST_XFER: begin
                if (beat) begin
                    din_next       = ch_word[owner_reg];
                    din_valid_next = 1'b1;
                    wd_cnt_next    = '0;
                    if (CH_LAST[owner_reg]) begin
                        last_grant_next = owner_reg;
                        grant_next      = '0;
                        state_next      = ST_IDLE;
                    end
                end else if (stall) begin
                    if (wd_cnt_reg == WD_LAST) begin
                        // Abort: remainder of the packet is dropped, the
                        // owner loses priority as if it had finished.
                        timeout_flag_next = 1'b1;
                        last_grant_next   = owner_reg;
                        grant_next        = '0;
                        wd_cnt_next       = '0;
                        state_next        = ST_IDLE;
                    end else begin
                        wd_cnt_next = wd_cnt_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        CH_READY = '0;
        if (state_reg == ST_XFER) begin
            CH_READY = grant_reg & {NUM_CH{CONVERT_READY}};
        end
    end

    assign DIN          = din_reg;
    assign DIN_VALID    = din_valid_reg;
    assign GRANT        = grant_reg;
    assign TIMEOUT_FLAG = timeout_flag_reg;

endmodule
